decryption128: RTL and testbench

Bit-serial ACORN-128 decryption engine, the receive-side counterpart of the encryption block. Starting from a 293-bit ACORN state, it decrypts one 128-bit ciphertext block LSB first. It then runs the 256-step message padding and returns the plaintext together with the updated state. Tag finalization and tag compare are handled downstream.

---
 rtl/acorn128_pkg.sv | 44 ++++
 rtl/acorn128_step.sv | 57 +++++
 rtl/decryption128.sv | 132 +++++++++++++
 tb/tb_decryption128.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// acorn128_pkg
// Shared definitions for the ACORN-128 encryption and decryption engines:
// state width, block/padding step counts, state tap positions, the FSM
// state type and the two boolean helpers (majority and choose) used by the
// keystream and feedback equations.
package acorn128_pkg;

    localparam int STATE_W    = 293;
    localparam int NSTEP_DATA = 128;
    localparam int NSTEP_PAD  = 256;

    // State tap positions
    localparam int T0   = 0;
    localparam int T12  = 12;
    localparam int T23  = 23;
    localparam int T61  = 61;
    localparam int T66  = 66;
    localparam int T107 = 107;
    localparam int T111 = 111;
    localparam int T154 = 154;
    localparam int T160 = 160;
    localparam int T193 = 193;
    localparam int T196 = 196;
    localparam int T230 = 230;
    localparam int T235 = 235;
    localparam int T244 = 244;
    localparam int T289 = 289;
    localparam int T292 = 292;

    // FSM encoding kept as plain constants so older blocks can share it
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

endpackage

// File: rtl/acorn128_step.sv
// acorn128_step
// One combinational ACORN-128 state update, shared by the encryption and
// decryption paths.
// Ports:
//   s_i          current 293-bit state S[292:0]
//   m_i          message bit (used when dec_i=0)
//   ca_i, cb_i   control bits
//   dec_i        1: message bit is recovered as cipher_bit_i ^ ks
//   cipher_bit_i ciphertext bit for decryption
//   s_o          next state
//   ks_o         keystream bit of this step
//   p_o          data output: plaintext when decrypting, ciphertext otherwise
module acorn128_step
    import acorn128_pkg::*;
(
    input  logic [STATE_W-1:0] s_i,
    input  logic               m_i,
    input  logic               ca_i,
    input  logic               cb_i,
    input  logic               dec_i,
    input  logic               cipher_bit_i,
    output logic [STATE_W-1:0] s_o,
    output logic               ks_o,
    output logic               p_o
);

    logic [STATE_W-1:0] t;
    logic               ks;
    logic               m;
    logic               f;

    // The six LFSR-segment updates are sequential: each one reads values
    // already modified by the ones above it, and the keystream and feedback
    // then see the fully updated state.
    always_comb begin
        t = s_i;
        t[T289] = t[T289] ^ t[T235] ^ t[T230];
        t[T230] = t[T230] ^ t[196]  ^ t[T193];
        t[T193] = t[T193] ^ t[T160] ^ t[T154];
        t[T154] = t[T154] ^ t[T111] ^ t[T107];
        t[T107] = t[T107] ^ t[T66]  ^ t[T61];
        t[T61]  = t[T61]  ^ t[T23]  ^ t[T0];

        ks = t[T12] ^ t[T154] ^ maj(t[T235], t[T61], t[T193])
                    ^ ch(t[T230], t[T111], t[T66]);

        m   = dec_i ? (cipher_bit_i ^ ks) : m_i;
        p_o = dec_i ? m : (m_i ^ ks);

        f = t[T0] ^ ~t[T107] ^ maj(t[T244], t[T23], t[T160])
                  ^ (ca_i & t[T196]) ^ (cb_i & ks) ^ m;

        s_o  = {f, t[T292:1]};
        ks_o = ks;
    end

endmodule

// File: rtl/decryption128.sv
// decryption128
// Bit-serial ACORN-128 decryption of one 128-bit block followed by the
// 256-step message padding. One step per clock.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          one-cycle request, honoured only while idle
//   state_in       starting ACORN state, captured on accepted start
//   cipher_in      ciphertext block, bit i used at step i
//   busy           high while stepping
//   done           one-cycle pulse when plaintext_out/state_out are valid
//   plaintext_out  decrypted block, written bit by bit
//   state_out      state after the last padding step
module decryption128
    import acorn128_pkg::STATE_W;
    import acorn128_pkg::fsm_state_t;
    import acorn128_pkg::ST_IDLE;
    import acorn128_pkg::ST_RUN;
    import acorn128_pkg::ST_DONE;
#(
    parameter int NSTEP_DATA = 128,
    parameter int NSTEP_PAD  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    input  logic [127:0]       cipher_in,
    output logic               busy,
    output logic               done,
    output logic [127:0]       plaintext_out,
    output logic [STATE_W-1:0] state_out
);

    localparam int         DW       = $clog2(NSTEP_DATA);
    localparam logic [8:0] K_DATA   = 9'(NSTEP_DATA);
    localparam logic [8:0] K_CA_END = 9'd256;
    localparam logic [8:0] K_LAST   = 9'(NSTEP_DATA + NSTEP_PAD - 1);
    localparam logic [8:0] K_FINISH = 9'(NSTEP_DATA + NSTEP_PAD);

    fsm_state_t         fsm_q;
    logic [8:0]         k_q;
    logic [STATE_W-1:0] s_q;
    logic [127:0]       cipher_q;
    logic [127:0]       plain_q;
    logic [STATE_W-1:0] stateOut_q;
    logic               busy_q;
    logic               done_q;

    logic [STATE_W-1:0] s_d;
    logic               ks;
    logic               p;
    logic               dec;
    logic               mPad;
    logic               ca;

    // Data steps decrypt; the first padding step injects a single 1 bit,
    // the remaining ones inject 0. ca stays high for the first 256 steps.
    always_comb begin
        dec  = (k_q < K_DATA);
        mPad = (k_q == K_DATA);
        ca   = (k_q < K_CA_END);
    end

    acorn128_step u_step (
        .s_i          (s_q),
        .m_i          (mPad),
        .ca_i         (ca),
        .cb_i         (1'b0),
        .dec_i        (dec),
        .cipher_bit_i (cipher_q[k_q[DW-1:0]]),
        .s_o          (s_d),
        .ks_o         (ks),
        .p_o          (p)
    );

    // Control and datapath. RUN lasts one cycle beyond the last step
    // (k = K_FINISH performs no step) so that done lands 385 clocks after
    // the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            k_q        <= '0;
            s_q        <= '0;
            cipher_q   <= '0;
            plain_q    <= '0;
            stateOut_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        s_q      <= state_in;
                        cipher_q <= cipher_in;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        fsm_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (k_q == K_FINISH) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= ST_DONE;
                    end else begin
                        s_q <= s_d;
                        k_q <= k_q + 9'd1;
                        if (dec) begin
                            plain_q[k_q[DW-1:0]] <= p;
                        end
                        if (k_q == K_LAST) begin
                            stateOut_q <= s_d;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    fsm_q  <= ST_IDLE;
                end
                default: begin
                    fsm_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign plaintext_out = plain_q;
    assign state_out     = stateOut_q;

endmodule

// File: tb/tb_decryption128.sv
// tb_decryption128
// Self-checking bench for decryption128: reference model operating on a bit
// array, a table of random vectors, round-trip against a software encryptor,
// and hand-written sequences for start/reset timing corner cases.
module tb_decryption128;

    typedef struct {
        logic [292:0] st;
        logic [127:0] ct;
        logic [127:0] expP;
        logic [292:0] expS;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [292:0] state_in;
    logic [127:0] cipher_in;
    logic         busy;
    logic         done;
    logic [127:0] plaintext_out;
    logic [292:0] state_out;

    int compared   = 0;
    int mismatched = 0;

    decryption128 dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .state_in      (state_in),
        .cipher_in     (cipher_in),
        .busy          (busy),
        .done          (done),
        .plaintext_out (plaintext_out),
        .state_out     (state_out)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point; every failure reports name, actual, required
    task automatic checkOutput(input string name, input logic [292:0] actual,
                               input logic [292:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    function automatic bit fMaj(input bit x, input bit y, input bit z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic bit fCh(input bit x, input bit y, input bit z);
        return x ? y : z;
    endfunction

    // Reference ACORN-128 block + padding, straight from the step rules.
    // encrypt=1: din is plaintext, dout ciphertext; encrypt=0: the reverse.
    function automatic void refModel(input logic [292:0] si, input logic [127:0] din,
                                     input bit encrypt, output logic [127:0] dout,
                                     output logic [292:0] so);
        bit s[293];
        bit ks, m, ca, f;
        for (int j = 0; j < 293; j++) s[j] = si[j];
        dout = '0;
        for (int k = 0; k < 384; k++) begin
            s[289] = s[289] ^ s[235] ^ s[230];
            s[230] = s[230] ^ s[196] ^ s[193];
            s[193] = s[193] ^ s[160] ^ s[154];
            s[154] = s[154] ^ s[111] ^ s[107];
            s[107] = s[107] ^ s[66]  ^ s[61];
            s[61]  = s[61]  ^ s[23]  ^ s[0];
            ks = s[12] ^ s[154] ^ fMaj(s[235], s[61], s[193]) ^ fCh(s[230], s[111], s[66]);
            if (k < 128) begin
                if (encrypt) begin
                    m = din[k];
                    dout[k] = m ^ ks;
                end else begin
                    m = din[k] ^ ks;
                    dout[k] = m;
                end
            end else begin
                m = (k == 128);
            end
            ca = (k < 256);
            f = s[0] ^ !s[107] ^ fMaj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ m;
            for (int j = 0; j < 292; j++) s[j] = s[j + 1];
            s[292] = f;
        end
        for (int j = 0; j < 293; j++) so[j] = s[j];
    endfunction

    function automatic logic [292:0] rand293();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r[292:0];
    endfunction

    // Caller sits at a negedge. Pulses start, scrambles the inputs afterwards
    // (they must have been latched), optionally re-pulses start at the given
    // cycle numbers, and returns at the negedge where done is seen.
    task automatic applyStimulus(input logic [292:0] si, input logic [127:0] ci,
                                 input int glitchA, input int glitchB,
                                 output int cycles, output logic busyAt1);
        start     = 1'b1;
        state_in  = si;
        cipher_in = ci;
        @(negedge clk);
        start     = 1'b0;
        state_in  = rand293();
        cipher_in = {$urandom, $urandom, $urandom, $urandom};
        cycles    = 0;
        busyAt1   = 1'b0;
        while (cycles < 1000) begin
            start = ((cycles + 1) == glitchA) || ((cycles + 1) == glitchB);
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1) busyAt1 = busy;
            if (done) break;
        end
        start = 1'b0;
    endtask

    vec_t         vec[4];
    logic [292:0] expS, rtState, encState;
    logic [127:0] expP, ct, ptOrig;
    logic [127:0] holdP;
    logic [292:0] holdS;
    int           cyc;
    int           extraDone;
    logic         b1;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        state_in  = '0;
        cipher_in = '0;

        // Reference vectors for the table
        for (int i = 0; i < 4; i++) begin
            vec[i].st = rand293();
            vec[i].ct = {$urandom, $urandom, $urandom, $urandom};
            refModel(vec[i].st, vec[i].ct, 1'b0, vec[i].expP, vec[i].expS);
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 293'(busy), 293'(0));
        checkOutput("reset_done", 293'(done), 293'(0));
        checkOutput("reset_plain", 293'(plaintext_out), 293'(0));
        checkOutput("reset_state", state_out, 293'(0));
        rst = 1'b0;
        @(negedge clk);

        // All-zero state and ciphertext
        refModel('0, '0, 1'b0, expP, expS);
        checkOutput("zero_model_p0", 293'(expP[0]), 293'(0));
        applyStimulus('0, '0, 0, 0, cyc, b1);
        checkOutput("zero_busy_early", 293'(b1), 293'(1));
        checkOutput("zero_latency", 293'(cyc), 293'(385));
        checkOutput("zero_busy_at_done", 293'(busy), 293'(0));
        checkOutput("zero_plain", 293'(plaintext_out), 293'(expP));
        checkOutput("zero_state", state_out, expS);
        @(negedge clk);
        checkOutput("zero_done_one_cycle", 293'(done), 293'(0));

        // Round trip against the software encryptor
        rtState = {5'h15, {9{32'hA5C3_9E17}}};
        ptOrig  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        refModel(rtState, ptOrig, 1'b1, ct, encState);
        applyStimulus(rtState, ct, 0, 0, cyc, b1);
        checkOutput("rt_latency", 293'(cyc), 293'(385));
        checkOutput("rt_plain", 293'(plaintext_out), 293'(ptOrig));
        checkOutput("rt_state", state_out, encState);
        @(negedge clk);

        // Table of random vectors
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vec[i].st, vec[i].ct, 0, 0, cyc, b1);
            checkOutput($sformatf("kat%0d_latency", i), 293'(cyc), 293'(385));
            checkOutput($sformatf("kat%0d_plain", i), 293'(plaintext_out), 293'(vec[i].expP));
            checkOutput($sformatf("kat%0d_state", i), state_out, vec[i].expS);
            @(negedge clk);
        end

        // start pulses while busy are ignored
        applyStimulus(vec[0].st, vec[0].ct, 10, 200, cyc, b1);
        checkOutput("glitch_latency", 293'(cyc), 293'(385));
        checkOutput("glitch_plain", 293'(plaintext_out), 293'(vec[0].expP));
        checkOutput("glitch_state", state_out, vec[0].expS);
        extraDone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) extraDone++;
        end
        checkOutput("glitch_single_done", 293'(extraDone), 293'(0));
        checkOutput("glitch_idle", 293'(busy), 293'(0));

        // Reset in the middle of a run
        start     = 1'b1;
        state_in  = vec[1].st;
        cipher_in = vec[1].ct;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 293'(busy), 293'(0));
        checkOutput("abort_done", 293'(done), 293'(0));
        checkOutput("abort_plain", 293'(plaintext_out), 293'(0));
        checkOutput("abort_state", state_out, 293'(0));
        @(negedge clk);
        // start together with reset has no effect
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_beats_start", 293'(busy), 293'(0));
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        applyStimulus(vec[2].st, vec[2].ct, 0, 0, cyc, b1);
        checkOutput("post_rst_latency", 293'(cyc), 293'(385));
        checkOutput("post_rst_plain", 293'(plaintext_out), 293'(vec[2].expP));
        checkOutput("post_rst_state", state_out, vec[2].expS);

        // Back-to-back: start in the cycle right after done
        @(negedge clk);
        holdP = plaintext_out;
        holdS = state_out;
        checkOutput("b2b_hold_plain", 293'(holdP), 293'(vec[2].expP));
        checkOutput("b2b_hold_state", holdS, vec[2].expS);
        applyStimulus(vec[3].st, vec[3].ct, 0, 0, cyc, b1);
        checkOutput("b2b_latency", 293'(cyc), 293'(385));
        checkOutput("b2b_plain", 293'(plaintext_out), 293'(vec[3].expP));
        checkOutput("b2b_state", state_out, vec[3].expS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
